// File: rtl/ftdi_rx_packer.sv
// Packs bytes read from an FTDI FT245-style FIFO into 16-bit words and buffers
// them in a small first-word-fall-through FIFO with sticky overflow reporting.
module ftdi_rx_packer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [7:0]            data_i,
    input  logic                  rxf_n_i,
    input  logic                  rd_n_i,
    input  logic                  flush_i,
    input  logic                  clr_ovf_i,
    output logic [15:0]           m_data_o,
    output logic                  m_partial_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  almost_full_o,
    output logic                  overflow_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_AF   = (DEPTH_LOG2 + 1)'(DEPTH - 1);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        HAVE_LO = 1'b1
    } pack_state_t;

    pack_state_t state_q, state_d;
    logic [7:0]  lo_q;

    logic        accept;
    logic        push;
    logic        push_partial;
    logic [15:0] push_data;
    logic        load_lo;

    logic [16:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  overflow_q;
    logic                  full, pop, do_write, drop;

    assign accept = !rd_n_i && !rxf_n_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            lo_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            if (load_lo) begin
                lo_q <= data_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !flush_i) state_d = HAVE_LO;
            HAVE_LO: if (accept || flush_i)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A second byte always completes the word, so a coincident flush is moot.
    always_comb begin
        push         = 1'b0;
        push_partial = 1'b0;
        push_data    = 16'h0000;
        load_lo      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && flush_i) begin
                    push         = 1'b1;
                    push_partial = 1'b1;
                    push_data    = {8'h00, data_i};
                end else if (accept) begin
                    load_lo = 1'b1;
                end
            end
            HAVE_LO: begin
                if (accept) begin
                    push      = 1'b1;
                    push_data = {data_i, lo_q};
                end else if (flush_i) begin
                    push         = 1'b1;
                    push_partial = 1'b1;
                    push_data    = {8'h00, lo_q};
                end
            end
            default: ;
        endcase
    end

    assign full          = (level_q == LVL_FULL);
    assign m_valid_o     = (level_q != '0);
    assign pop           = m_valid_o && m_ready_i;
    assign do_write      = push && (!full || pop);
    assign drop          = push && full && !pop;
    assign level_o       = level_q;
    assign almost_full_o = (level_q >= LVL_AF);
    assign overflow_o    = overflow_q;

    // Outputs are forced to zero when empty so stale entries never leak out.
    assign m_data_o    = m_valid_o ? mem_q[rd_ptr_q][15:0] : 16'h0000;
    assign m_partial_o = m_valid_o ? mem_q[rd_ptr_q][16]   : 1'b0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_write) begin
                mem_q[wr_ptr_q] <= {push_partial, push_data};
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (do_write && !pop) begin
                level_q <= level_q + LVL_ONE;
            end else if (pop && !do_write) begin
                level_q <= level_q - LVL_ONE;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

endmodule
